// File: rtl/runner.sv
// runner_pkg: shared types for the runner game block (render slot count, sprite codes, screen position).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package runner_pkg;

  localparam int RENDER_SLOTS = 8;

  typedef enum logic [3:0] {
    NONE       = 4'd0,
    TREX_STAND = 4'd1,
    TREX_RUN1  = 4'd2,
    TREX_RUN2  = 4'd3,
    TREX_DUCK1 = 4'd4,
    TREX_DUCK2 = 4'd5
  } sprite_t;

  // Screen pixels, top-left corner of the sprite.
  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
  } pos_t;

endpackage

// runner: T-rex runner state machine (wait / run / jump / duck) with fixed-point jump physics and
//         run/duck animation, driving render slot 0; slots 1..RENDER_SLOTS-1 are always blank.
// Latency: inputs sampled on a cycle with update=1; outputs show the new state the following cycle.
// Backpressure: none; update is a frame strobe and cycles with update=0 hold all state.
// Ports: clk, rst (sync, active-high) | update, jumping, ducking (inputs) | sprite[], pos[] (outputs).
module runner
  import runner_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          update,
  input  logic                          jumping,
  input  logic                          ducking,
  output sprite_t [RENDER_SLOTS-1:0]    sprite,
  output pos_t    [RENDER_SLOTS-1:0]    pos
);

  // Geometry in pixels; y is tracked internally as 1/16 pixel fixed point.
  localparam logic signed [10:0] X_POS    = 11'sd50;
  localparam logic signed [9:0]  DUCK_Y   = 10'sd110;
  localparam logic signed [15:0] GROUND_FP = 16'sd1488;  // 93 * 16
  // "y <= N pixels" after floor(y_fp/16) is the same as y_fp < (N+1)*16.
  localparam logic signed [15:0] MIN_JUMP_LIM = 16'sd1024; // y <= 63
  localparam logic signed [15:0] MAX_JUMP_LIM = 16'sd464;  // y <= 28

  localparam logic signed [11:0] JUMP_VEL     = -12'sd160;
  localparam logic signed [11:0] DROP_VEL     = -12'sd80;
  localparam logic signed [11:0] GRAVITY      = 12'sd10;
  localparam logic signed [11:0] GRAVITY_DUCK = 12'sd30;

  localparam logic [2:0] FRAME_LAST = 3'd4;

  typedef enum logic [1:0] {
    WAITING = 2'd0,
    RUNNING = 2'd1,
    JUMPING = 2'd2,
    DUCKING = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic signed [15:0] y_fp_q, y_fp_d;
  logic signed [11:0] vel_q, vel_d;
  logic               end_req_q, end_req_d;
  logic [2:0]         frame_cnt_q, frame_cnt_d;
  logic               frame_q, frame_d;

  // One physics step of the jump, evaluated every cycle, committed only in JUMPING on update.
  logic signed [15:0] y_step;
  logic signed [11:0] vel_step;
  logic               end_req_step;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAITING;
      y_fp_q      <= GROUND_FP;
      vel_q       <= '0;
      end_req_q   <= 1'b0;
      frame_cnt_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_fp_q      <= y_fp_d;
      vel_q       <= vel_d;
      end_req_q   <= end_req_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    y_fp_d       = y_fp_q;
    vel_d        = vel_q;
    end_req_d    = end_req_q;
    frame_cnt_d  = frame_cnt_q;
    frame_d      = frame_q;

    y_step       = y_fp_q + {{4{vel_q[11]}}, vel_q};
    vel_step     = vel_q + (ducking ? GRAVITY_DUCK : GRAVITY);
    // Releasing the key once is remembered for the rest of the jump.
    end_req_step = end_req_q | ~jumping;

    if (update) begin
      unique case (state_q)
        WAITING: begin
          if (jumping) begin
            state_d   = JUMPING;
            vel_d     = JUMP_VEL;
            end_req_d = 1'b0;
          end
        end

        RUNNING: begin
          if (ducking) begin
            state_d = DUCKING;
          end else if (jumping) begin
            state_d   = JUMPING;
            vel_d     = JUMP_VEL;
            end_req_d = 1'b0;
          end
        end

        DUCKING: begin
          // y_fp stays at ground level; the lowered duck height is an output-only offset.
          if (!ducking) begin
            state_d = RUNNING;
            y_fp_d  = GROUND_FP;
          end
        end

        JUMPING: begin
          y_fp_d    = y_step;
          vel_d     = vel_step;
          end_req_d = end_req_step;
          // Cut the remaining ascent short: after a release once past the minimum
          // height, or unconditionally at the ceiling.
          if (((end_req_step && (y_step < MIN_JUMP_LIM)) || (y_step < MAX_JUMP_LIM)) &&
              (vel_step < DROP_VEL)) begin
            vel_d = DROP_VEL;
          end
          if (y_step >= GROUND_FP) begin
            y_fp_d    = GROUND_FP;
            vel_d     = '0;
            end_req_d = 1'b0;
            state_d   = ducking ? DUCKING : RUNNING;
          end
        end

        default: state_d = WAITING;
      endcase

      // Animation: 5 updates per frame, restarting on any state change.
      if (state_d != state_q) begin
        frame_cnt_d = '0;
        frame_d     = 1'b0;
      end else if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        frame_d     = ~frame_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < RENDER_SLOTS; i++) begin
      sprite[i] = NONE;
      pos[i]    = '0;
    end

    unique case (state_q)
      RUNNING: sprite[0] = frame_q ? TREX_RUN2 : TREX_RUN1;
      DUCKING: sprite[0] = frame_q ? TREX_DUCK2 : TREX_DUCK1;
      default: sprite[0] = TREX_STAND;
    endcase

    pos[0].x = X_POS;
    // Bits [13:4] are floor(y_fp/16) truncated to the 10-bit screen coordinate.
    pos[0].y = (state_q == DUCKING) ? DUCK_Y : y_fp_q[13:4];
  end

endmodule

// File: tb/tb_runner.sv
`timescale 1ns/1ps
module tb_runner;
  import runner_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic update;
  logic jumping;
  logic ducking;
  sprite_t [RENDER_SLOTS-1:0] sprite;
  pos_t    [RENDER_SLOTS-1:0] pos;

  runner dut (
    .clk     (clk),
    .rst     (rst),
    .update  (update),
    .jumping (jumping),
    .ducking (ducking),
    .sprite  (sprite),
    .pos     (pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int spr;
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: game rules in plain integer arithmetic.
  // Height is kept in 1/16 pixels; animation frame is derived from the number
  // of updates spent in the current mode.
  // ---------------------------------------------------------------------------
  localparam int M_WAIT = 0, M_RUN = 1, M_JUMP = 2, M_DUCK = 3;
  int mode;
  int y16;
  int vel;
  int upd_in_mode;
  bit end_req;

  task automatic model_step(input bit r, input bit u, input bit j, input bit d);
    int   prev;
    int   ny;
    int   nv;
    bit   ne;
    exp_t e;
    if (r) begin
      mode = M_WAIT; y16 = 93 * 16; vel = 0; end_req = 0; upd_in_mode = 0;
    end else if (u) begin
      prev = mode;
      case (mode)
        M_WAIT: if (j) begin mode = M_JUMP; vel = -160; end_req = 0; end
        M_RUN: begin
          if (d) mode = M_DUCK;
          else if (j) begin mode = M_JUMP; vel = -160; end_req = 0; end
        end
        M_DUCK: if (!d) begin mode = M_RUN; y16 = 93 * 16; end
        default: begin
          ny = y16 + vel;
          nv = vel + (d ? 30 : 10);
          ne = end_req | !j;
          if (((ne && (ny >>> 4) <= 63) || (ny >>> 4) <= 28) && nv < -80) nv = -80;
          if (ny >= 93 * 16) begin
            ny = 93 * 16; nv = 0; ne = 0;
            mode = d ? M_DUCK : M_RUN;
          end
          y16 = ny; vel = nv; end_req = ne;
        end
      endcase
      if (mode != prev) upd_in_mode = 0;
      else upd_in_mode++;
    end
    e.x = 50;
    e.y = (mode == M_DUCK) ? 110 : (y16 >>> 4);
    case (mode)
      M_RUN:   e.spr = ((upd_in_mode / 5) % 2 == 1) ? 3 : 2;
      M_DUCK:  e.spr = ((upd_in_mode / 5) % 2 == 1) ? 5 : 4;
      default: e.spr = 1;
    endcase
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change on the falling edge, expectation pushed at once.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit r, input bit u, input bit j, input bit d);
    @(negedge clk);
    rst = r; update = u; jumping = j; ducking = d;
    model_step(r, u, j, d);
  endtask

  // n updates with held keys, each followed by 0..2 idle cycles whose key
  // values are random (they must be ignored).
  task automatic upd(input bit j, input bit d, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, j, d);
      for (int g = $urandom_range(2); g > 0; g--)
        drive(1'b0, 1'b0, $urandom_range(1) == 1, $urandom_range(1) == 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per cycle, sampled 1ns after the edge.
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("slot0_sprite", int'(sprite[0]), e.spr);
        check("slot0_x", int'(pos[0].x), e.x);
        check("slot0_y", int'(pos[0].y), e.y);
        for (int i = 1; i < RENDER_SLOTS; i++)
          check("slot_blank", int'({sprite[i], pos[i]}), 0);
      end
    end
  end

  initial begin
    bit j;
    bit d;
    // Reset applied from time zero, overriding update.
    rst = 1'b1; update = 1'b1; jumping = 1'b1; ducking = 1'b0;
    model_step(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Idle: 20 updates, runner stays standing.
    upd(1'b0, 1'b0, 20);
    // Held jump: ascent, ceiling, landing and relaunch.
    upd(1'b1, 1'b0, 70);
    // Let it land, then a short tap from running.
    upd(1'b0, 1'b0, 40);
    upd(1'b1, 1'b0, 2);
    upd(1'b0, 1'b0, 45);
    // Ducking animation, release, then duck+jump together.
    upd(1'b0, 1'b1, 12);
    upd(1'b0, 1'b0, 3);
    upd(1'b1, 1'b1, 8);
    upd(1'b0, 1'b0, 2);
    // Duck in the air lands into ducking.
    upd(1'b1, 1'b0, 3);
    upd(1'b0, 1'b1, 25);
    // Reset mid-jump with update high.
    upd(1'b0, 1'b0, 3);
    upd(1'b1, 1'b0, 5);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    upd(1'b0, 1'b0, 3);

    // Random play with sticky keys and rare resets.
    j = 1'b0; d = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) j = !j;
      if ($urandom_range(11) == 0) d = !d;
      drive($urandom_range(399) == 0, $urandom_range(1) == 1, j, d);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    done = 1'b1;
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/runner.md
RUNNER -- requirements
Module: runner

Interface
REQ-001 Parameter/constant: RENDER_SLOTS, 8 (from runner_pkg), number of sprite/position output slots.
REQ-002 Type sprite_t (runner_pkg): 4-bit enum; NONE=0, TREX_STAND=1, TREX_RUN1=2, TREX_RUN2=3, TREX_DUCK1=4, TREX_DUCK2=5.
REQ-003 Type pos_t (runner_pkg): packed struct {x signed 11 bits, y signed 10 bits}; screen pixels, top-left of sprite.
REQ-004 clk  input  1  system clock; one clock only.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 update  input  1  one-cycle frame strobe; all state advances only on cycles with update=1.
REQ-007 jumping  input  1  level, jump key held.
REQ-008 ducking  input  1  level, duck key held.
REQ-009 sprite  output  sprite_t[RENDER_SLOTS]  sprite per render slot.
REQ-010 pos  output  pos_t[RENDER_SLOTS]  position per render slot.

Function
REQ-011 Slot 0 carries the runner; slots 1..RENDER_SLOTS-1 SHALL always output sprite NONE, pos (0,0).
REQ-012 States: WAITING, RUNNING, JUMPING, DUCKING; inputs SHALL be sampled only when update=1; outputs registered, reflecting the new state the cycle after the update cycle.
REQ-013 Constants: X=50, GROUND_Y=93, DUCK_Y=110, MIN_JUMP_Y=63, MAX_JUMP_Y=28; fixed-point y_fp = pixels*16, velocity vel signed 1/16 px per update.
REQ-014 Jump constants: JUMP_VEL=-160, DROP_VEL=-80, GRAVITY=10, duck-in-air gravity=30.
REQ-015 pos.y SHALL be y_fp arithmetic-shifted right by 4 (floor); pos.x SHALL always be 50.
REQ-016 WAITING: sprite TREX_STAND at (50,93); update with jumping=1 -> JUMPING with vel=JUMP_VEL, y unchanged that update.
REQ-017 RUNNING: update with jumping=1 and ducking=0 -> JUMPING (vel=JUMP_VEL, y unchanged); ducking=1 -> DUCKING (ducking has priority).
REQ-018 DUCKING: y=DUCK_Y; update with ducking=0 -> RUNNING, y=GROUND_Y; jumping ignored while ducking.
REQ-019 JUMPING, each later update: y_fp += vel, then vel += GRAVITY (30 if ducking=1); sprite TREX_STAND.
REQ-020 Jump release: jumping=0 latches end_req; when end_req set, y <= MIN_JUMP_Y and vel < DROP_VEL -> vel=DROP_VEL.
REQ-021 Max height: y <= MAX_JUMP_Y and vel < DROP_VEL -> vel=DROP_VEL regardless of key.
REQ-022 Landing: after an update y_fp >= GROUND_Y*16 -> y_fp=GROUND_Y*16, vel=0, end_req cleared, next state RUNNING (DUCKING if ducking=1); a held jumping starts a new jump on the following update.
REQ-023 Animation: frame counter counts updates 0..4; on wrap, toggle frame bit; RUNNING shows RUN1/RUN2, DUCKING shows DUCK1/DUCK2; counter and frame bit clear on any state change.
REQ-024 Arithmetic: y_fp 16-bit signed, vel 12-bit signed; no saturation needed within these constants.
REQ-025 Cycles with update=0 SHALL hold all state and outputs.

Reset
REQ-026 rst=1 at a clock edge SHALL, regardless of update or state (including mid-jump): state WAITING, y_fp=1488, vel=0, end_req=0, frame counter/bit=0.
REQ-027 Output after reset: slot 0 TREX_STAND at (50,93); other slots NONE at (0,0); rst overrides update in the same cycle.

Verification
REQ-028 Reset, no inputs, 20 updates -> slot 0 stays TREX_STAND (50,93), slots 1..7 NONE.
REQ-029 WAITING, jumping=1 one update -> JUMPING, y 93; next two updates (key held) -> y 83 then 73.
REQ-030 Jump held throughout -> y reaches <= 28, vel clamped to -80, lands at y=93 and restarts jump on next update while held.
REQ-031 Short tap (jumping for 2 updates) -> clamp to DROP_VEL applied when y first <= 63; lands at 93, sprite then RUN1, toggling to RUN2 after 5 updates.
REQ-032 RUNNING, ducking=1 -> DUCK1 at (50,110), DUCK2 after 5 updates; ducking=0 -> RUN1 at (50,93); jumping+ducking together -> stays DUCKING.
REQ-033 rst asserted mid-jump with update=1 -> next cycle TREX_STAND (50,93), WAITING.
